// File: rtl/alu_seq_acc_if.sv
// Handshake bundle for alu_seq_acc: operand/op request channel and result/flag response channel.
// master drives requests and accepts results; slave is the ALU itself.
interface alu_seq_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, a, b, op, acc_sel, out_ready,
        input  in_ready, out_valid, y, flags, busy
    );

    modport slave (
        input  in_valid, a, b, op, acc_sel, out_ready,
        output in_ready, out_valid, y, flags, busy
    );
endinterface

// File: rtl/alu_seq_acc.sv
// Registered ALU with valid/ready handshake, iterative shift-add multiplier,
// {C,V,N,Z} flags and an accumulator selectable as operand A.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | ready for a bundle; non-MUL result registered on accept
//   MUL     | one shift-add step per cycle, down-counter from WIDTH to 1
//   DONE    | result/flags held with out_valid until out_ready
module alu_seq_acc #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_acc_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   y_q;
    logic [3:0]         flags_q;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               is_mul;
    logic               mul_last;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;

    logic [WIDTH-1:0]   alu_y;
    logic               alu_c;
    logic               alu_v;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic               shift_zero;
    logic               shift_big;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;

    assign opa      = bus.acc_sel ? acc : bus.a;
    assign opb      = bus.b;
    assign accept   = bus.in_valid && bus.in_ready;
    assign is_mul   = (MUL_EN != 0) && (bus.op == OP_MUL);
    assign mul_last = (cnt == CW'(1));

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit (prod[0]) is set, then shift the whole product right.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {mul_sum, prod[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Single-cycle operations on the live inputs, registered on accept.
    // ------------------------------------------------------------------
    always_comb begin
        alu_y      = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        sum_ext    = {1'b0, opa} + {1'b0, opb};
        diff       = opa - opb;
        shl_ext    = {1'b0, opa} << opb;
        shr_ext    = {opa, 1'b0} >> opb;
        shift_zero = (opb == '0);
        shift_big  = (opb >= W_VAL);
        case (bus.op)
            OP_ADD: begin
                alu_y = sum_ext[WIDTH-1:0];
                alu_c = sum_ext[WIDTH];
                alu_v = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_y[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y = diff;
                alu_c = (opa < opb);
                alu_v = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_y[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: alu_y = opa & opb;
            OP_OR:  alu_y = opa | opb;
            OP_XOR: alu_y = opa ^ opb;
            OP_SHL: begin
                if (shift_zero) begin
                    alu_y = opa;
                end else if (!shift_big) begin
                    {alu_c, alu_y} = shl_ext;
                end
            end
            OP_SHR: begin
                if (shift_zero) begin
                    alu_y = opa;
                end else if (!shift_big) begin
                    {alu_y, alu_c} = shr_ext;
                end
            end
            // Reached only with the multiplier compiled out: MUL degrades to AND.
            default: alu_y = opa & opb;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = is_mul ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE) && !rst;
        bus.out_valid = (state == ST_DONE);
        bus.busy      = (state == ST_MUL) || (state == ST_DONE);
        bus.y         = y_q;
        bus.flags     = flags_q;
    end

    // ------------------------------------------------------------------
    // Datapath: result/flag/accumulator registers and multiplier state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            flags_q <= '0;
            acc     <= '0;
            mcand   <= '0;
            prod    <= '0;
            cnt     <= '0;
        end else begin
            if (state == ST_IDLE && accept) begin
                if (is_mul) begin
                    mcand <= opa;
                    prod  <= {{WIDTH{1'b0}}, opb};
                    cnt   <= CW'(WIDTH);
                end else begin
                    y_q     <= alu_y;
                    flags_q <= {alu_c, alu_v, alu_y[WIDTH-1], (alu_y == '0)};
                    acc     <= alu_y;
                end
            end
            if (state == ST_MUL) begin
                prod <= prod_step;
                cnt  <= cnt - CW'(1);
                // The last step's product is taken straight into the result so
                // DONE is entered after exactly WIDTH multiplier cycles.
                if (mul_last) begin
                    y_q     <= prod_step[WIDTH-1:0];
                    flags_q <= {(|prod_step[2*WIDTH-1:WIDTH]), 1'b0,
                                prod_step[WIDTH-1], (prod_step[WIDTH-1:0] == '0)};
                    acc     <= prod_step[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_acc.sv
// Directed and randomized bench for alu_seq_acc; results compared against an
// arithmetic reference model of the ALU operations and accumulator.
module tb_alu_seq_acc;
    logic clk = 1'b0;
    logic rst;

    alu_seq_acc_if #(.WIDTH(8)) bus ();

    alu_seq_acc #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] model_acc;
    logic [7:0] oy;
    logic [3:0] of;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Returns {C,V,N,Z, y} from plain integer arithmetic on 8-bit operands.
    function automatic logic [11:0] ref_op(input int op, input int A, input int B);
        int y, c, v, sa, sb, sr, p;
        y = 0; c = 0; v = 0;
        sa = (A >= 128) ? A - 256 : A;
        sb = (B >= 128) ? B - 256 : B;
        case (op)
            0: begin
                y = (A + B) % 256; c = (A + B > 255) ? 1 : 0;
                sr = sa + sb; v = (sr > 127 || sr < -128) ? 1 : 0;
            end
            1: begin
                y = (A - B + 256) % 256; c = (A < B) ? 1 : 0;
                sr = sa - sb; v = (sr > 127 || sr < -128) ? 1 : 0;
            end
            2: y = A & B;
            3: y = A | B;
            4: y = A ^ B;
            5: begin
                if (B == 0) y = A;
                else if (B >= 8) y = 0;
                else begin y = (A * (1 << B)) % 256; c = (A / (1 << (8 - B))) % 2; end
            end
            6: begin
                if (B == 0) y = A;
                else if (B >= 8) y = 0;
                else begin y = A / (1 << B); c = (A / (1 << (B - 1))) % 2; end
            end
            default: begin
                p = A * B; y = p % 256; c = (p > 255) ? 1 : 0;
            end
        endcase
        return {c[0], v[0], (y >= 128), (y == 0), y[7:0]};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic acc_sel, input int hold,
                          output logic [7:0] ry, output logic [3:0] rf);
        logic [11:0] r;
        int waited, lat, exp_lat;
        logic saw_ready;
        r = ref_op(int'(op), acc_sel ? int'(model_acc) : int'(a), int'(b));
        exp_lat = (op == 3'b111) ? 9 : 1;
        bus.op = op; bus.a = a; bus.b = b; bus.acc_sel = acc_sel;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin tick; waited++; end
        check({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        lat = 1; saw_ready = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) saw_ready = 1'b1;
            tick;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (op == 3'b111) check({tag, "_ready_in_mul"}, 32'(saw_ready), 32'd0);
        check({tag, "_y"}, 32'(bus.y), 32'(r[7:0]));
        check({tag, "_flags"}, 32'(bus.flags), 32'(r[11:8]));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        ry = bus.y; rf = bus.flags;
        model_acc = r[7:0];
        for (int h = 0; h < hold; h++) begin
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            bus.in_valid = 1'($urandom_range(0, 1));
            tick;
            check({tag, "_hold_y"}, 32'(bus.y), 32'(r[7:0]));
            check({tag, "_hold_flags"}, 32'(bus.flags), 32'(r[11:8]));
            check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.op = '0; bus.acc_sel = 1'b0;
        model_acc = '0;
        repeat (2) tick;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        tick;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);

        run_op("acc_zero", 3'b000, 8'hAA, 8'h03, 1'b1, 0, oy, of);
        check("acc_zero_lit", 32'(oy), 32'h03);

        run_op("t1_add", 3'b000, 8'hFF, 8'h01, 1'b0, 0, oy, of);
        check("t1_y_lit", 32'(oy), 32'h00);
        check("t1_flags_lit", 32'(of), 32'b1001);

        run_op("t2_sub_ovf", 3'b001, 8'h80, 8'h01, 1'b0, 0, oy, of);
        check("t2a_y_lit", 32'(oy), 32'h7F);
        check("t2a_flags_lit", 32'(of), 32'b0100);
        run_op("t2_sub_brw", 3'b001, 8'h01, 8'h02, 1'b0, 0, oy, of);
        check("t2b_y_lit", 32'(oy), 32'hFF);
        check("t2b_flags_lit", 32'(of), 32'b1010);

        run_op("t3_mul_hi", 3'b111, 8'h10, 8'h20, 1'b0, 0, oy, of);
        check("t3a_y_lit", 32'(oy), 32'h00);
        check("t3a_flags_lit", 32'(of), 32'b1001);
        run_op("t3_mul_lo", 3'b111, 8'd12, 8'd10, 1'b0, 0, oy, of);
        check("t3b_y_lit", 32'(oy), 32'h78);
        check("t3b_flags_lit", 32'(of), 32'b0000);

        run_op("t4_hold", 3'b000, 8'h55, 8'h2A, 1'b0, 5, oy, of);

        run_op("t5_add", 3'b000, 8'd3, 8'd4, 1'b0, 0, oy, of);
        run_op("t5_acc_add", 3'b000, 8'hEE, 8'd5, 1'b1, 0, oy, of);
        check("t5_acc_y_lit", 32'(oy), 32'h0C);
        run_op("t5_shl8", 3'b101, 8'hEE, 8'd8, 1'b1, 0, oy, of);
        check("t5_shl_y_lit", 32'(oy), 32'h00);
        check("t5_shl_flags_lit", 32'(of), 32'b0001);
        run_op("t5_shr1", 3'b110, 8'h81, 8'd1, 1'b0, 0, oy, of);
        check("t5_shr_y_lit", 32'(oy), 32'h40);
        check("t5_shr_flags_lit", 32'(of), 32'b1000);

        bus.op = 3'b111; bus.a = 8'h37; bus.b = 8'h5B; bus.acc_sel = 1'b0;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (3) tick;
        check("t6_busy_in_mul", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_y", 32'(bus.y), 32'd0);
        check("t6_rst_flags", 32'(bus.flags), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) tick;
        rst = 1'b0;
        model_acc = '0;
        tick;
        check("t6_ready_after_rst", 32'(bus.in_ready), 32'd1);
        run_op("t6_add", 3'b000, 8'd1, 8'd1, 1'b0, 0, oy, of);
        check("t6_y_lit", 32'(oy), 32'h02);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = ((rop == 3'b101 || rop == 3'b110) && $urandom_range(0, 1) == 1)
                 ? 8'($urandom_range(0, 9)) : 8'($urandom);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb,
                   1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), oy, of);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
